// File: rtl/input_pkg.sv
// rtl/input_pkg.sv - shared constants, key map decode and coin FSM state type for input_mapper
package input_pkg;

  // PS/2 set-2 scan codes
  localparam logic [7:0] SC_P1_UP    = 8'h75;
  localparam logic [7:0] SC_P1_DOWN  = 8'h72;
  localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT = 8'h74;
  localparam logic [7:0] SC_P1_B1    = 8'h14;
  localparam logic [7:0] SC_P1_B2    = 8'h11;
  localparam logic [7:0] SC_P1_B3    = 8'h29;
  localparam logic [7:0] SC_P1_START = 8'h16;
  localparam logic [7:0] SC_P1_COIN  = 8'h2E;
  localparam logic [7:0] SC_P1_PAUSE = 8'h4D;
  localparam logic [7:0] SC_P2_UP    = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT  = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT = 8'h34;
  localparam logic [7:0] SC_P2_B1    = 8'h1C;
  localparam logic [7:0] SC_P2_B2    = 8'h1B;
  localparam logic [7:0] SC_P2_B3    = 8'h15;
  localparam logic [7:0] SC_P2_START = 8'h1E;
  localparam logic [7:0] SC_P2_COIN  = 8'h36;
  localparam logic [7:0] SC_SERVICE1 = 8'h46;
  localparam logic [7:0] SC_SERVICE2 = 8'h45;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_B1    = 4;
  localparam int JOY_B2    = 5;
  localparam int JOY_B3    = 6;
  localparam int JOY_START = 7;
  localparam int JOY_COIN  = 8;
  localparam int JOY_PAUSE = 9;

  // Bit positions inside the key register vector
  localparam int K_P1_UP    = 0;
  localparam int K_P1_DOWN  = 1;
  localparam int K_P1_LEFT  = 2;
  localparam int K_P1_RIGHT = 3;
  localparam int K_P1_B1    = 4;
  localparam int K_P1_B2    = 5;
  localparam int K_P1_B3    = 6;
  localparam int K_P1_START = 7;
  localparam int K_P1_COIN  = 8;
  localparam int K_P1_PAUSE = 9;
  localparam int K_P2_UP    = 10;
  localparam int K_P2_DOWN  = 11;
  localparam int K_P2_LEFT  = 12;
  localparam int K_P2_RIGHT = 13;
  localparam int K_P2_B1    = 14;
  localparam int K_P2_B2    = 15;
  localparam int K_P2_B3    = 16;
  localparam int K_P2_START = 17;
  localparam int K_P2_COIN  = 18;
  localparam int K_SERVICE1 = 19;
  localparam int K_SERVICE2 = 20;
  localparam int NUM_KEYS   = 21;

  typedef enum logic [1:0] {
    COIN_IDLE   = 2'd0,
    COIN_ACTIVE = 2'd1,
    COIN_HOLD   = 2'd2
  } coin_state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic b1;
    logic b2;
    logic b3;
    logic start;
    logic coin;
    logic pause;
  } player_ctrl_t;

  function automatic logic [NUM_KEYS-1:0] key_decode(input logic [7:0] code);
    logic [NUM_KEYS-1:0] hit;
    hit = '0;
    case (code)
      SC_P1_UP:    hit[K_P1_UP]    = 1'b1;
      SC_P1_DOWN:  hit[K_P1_DOWN]  = 1'b1;
      SC_P1_LEFT:  hit[K_P1_LEFT]  = 1'b1;
      SC_P1_RIGHT: hit[K_P1_RIGHT] = 1'b1;
      SC_P1_B1:    hit[K_P1_B1]    = 1'b1;
      SC_P1_B2:    hit[K_P1_B2]    = 1'b1;
      SC_P1_B3:    hit[K_P1_B3]    = 1'b1;
      SC_P1_START: hit[K_P1_START] = 1'b1;
      SC_P1_COIN:  hit[K_P1_COIN]  = 1'b1;
      SC_P1_PAUSE: hit[K_P1_PAUSE] = 1'b1;
      SC_P2_UP:    hit[K_P2_UP]    = 1'b1;
      SC_P2_DOWN:  hit[K_P2_DOWN]  = 1'b1;
      SC_P2_LEFT:  hit[K_P2_LEFT]  = 1'b1;
      SC_P2_RIGHT: hit[K_P2_RIGHT] = 1'b1;
      SC_P2_B1:    hit[K_P2_B1]    = 1'b1;
      SC_P2_B2:    hit[K_P2_B2]    = 1'b1;
      SC_P2_B3:    hit[K_P2_B3]    = 1'b1;
      SC_P2_START: hit[K_P2_START] = 1'b1;
      SC_P2_COIN:  hit[K_P2_COIN]  = 1'b1;
      SC_SERVICE1: hit[K_SERVICE1] = 1'b1;
      SC_SERVICE2: hit[K_SERVICE2] = 1'b1;
      default:     hit = '0;
    endcase
    return hit;
  endfunction

  // Opposing directions held together cancel to neutral
  function automatic logic [1:0] axis_resolve(input logic a, input logic b);
    return {a & ~b, b & ~a};
  endfunction

endpackage

// File: rtl/coin_pulse.sv
// rtl/coin_pulse.sv - shapes a raw coin level into one fixed-width pulse per press
module coin_pulse
  import input_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 16
) (
  input  logic clk_sys,
  input  logic reset_sys_n,
  input  logic coin_raw,
  output logic coin_out
);

  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES - 1);

  coin_state_t state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        armed_q;
  logic        prev_q;
  logic        rise;

  // A level already high when reset lifts is not a new insertion
  assign rise = armed_q & coin_raw & ~prev_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      COIN_IDLE: begin
        if (rise) begin
          state_d = COIN_ACTIVE;
          count_d = PULSE_LOAD;
        end
      end
      COIN_ACTIVE: begin
        if (count_q == 16'd0) begin
          state_d = COIN_HOLD;
        end else begin
          count_d = count_q - 16'd1;
        end
      end
      COIN_HOLD: begin
        if (!coin_raw) begin
          state_d = COIN_IDLE;
        end
      end
      default: begin
        state_d = COIN_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_sys_n) begin
    if (!reset_sys_n) begin
      state_q  <= COIN_IDLE;
      count_q  <= '0;
      armed_q  <= 1'b0;
      prev_q   <= 1'b0;
      coin_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      armed_q  <= 1'b1;
      prev_q   <= coin_raw;
      coin_out <= (state_d == COIN_ACTIVE);
    end
  end

endmodule

// File: rtl/input_mapper.sv
// rtl/input_mapper.sv - merges PS/2 keys and joysticks into registered two-player controls
// Optional autofire on button 1 is built with INPUT_AUTOFIRE_EN defined.
module input_mapper
  import input_pkg::*;
#(
  parameter int unsigned COIN_PULSE_CYCLES = 16,
  parameter int unsigned AUTOFIRE_PERIOD   = 8
) (
  input  logic        clk_sys,
  input  logic        reset_sys_n,
  input  logic [10:0] ps2_key,
  input  logic [10:0] joystick_0,
  input  logic [10:0] joystick_1,
`ifdef INPUT_AUTOFIRE_EN
  input  logic        autofire_en,
`endif
  output logic [3:0]  p1_dir,
  output logic [2:0]  p1_buttons,
  output logic        p1_start,
  output logic        p1_coin,
  output logic        p1_pause,
  output logic [3:0]  p2_dir,
  output logic [2:0]  p2_buttons,
  output logic        p2_start,
  output logic        p2_coin,
  output logic        p2_pause,
  output logic        service1,
  output logic        service2
);

  logic                toggle_q;
  logic                kb_armed_q;
  logic                kb_event;
  logic [NUM_KEYS-1:0] key_hit;
  logic [NUM_KEYS-1:0] keys_q;
  player_ctrl_t        raw1, raw2;
  logic [1:0]          b1_raw;
  logic [1:0]          b1_out;
  logic                unused_inputs;

  assign unused_inputs = ^{ps2_key[8], joystick_0[10], joystick_1[10]};

  // The toggle register is loaded without comparing on the first cycle out of reset
  assign kb_event = kb_armed_q & (ps2_key[10] ^ toggle_q);
  assign key_hit  = key_decode(ps2_key[7:0]);

  always_ff @(posedge clk_sys or negedge reset_sys_n) begin
    if (!reset_sys_n) begin
      toggle_q   <= 1'b0;
      kb_armed_q <= 1'b0;
      keys_q     <= '0;
    end else begin
      toggle_q   <= ps2_key[10];
      kb_armed_q <= 1'b1;
      if (kb_event) begin
        keys_q <= (keys_q & ~key_hit) | (key_hit & {NUM_KEYS{ps2_key[9]}});
      end
    end
  end

  always_comb begin
    raw1.up    = keys_q[K_P1_UP]    | joystick_0[JOY_UP];
    raw1.down  = keys_q[K_P1_DOWN]  | joystick_0[JOY_DOWN];
    raw1.left  = keys_q[K_P1_LEFT]  | joystick_0[JOY_LEFT];
    raw1.right = keys_q[K_P1_RIGHT] | joystick_0[JOY_RIGHT];
    raw1.b1    = keys_q[K_P1_B1]    | joystick_0[JOY_B1];
    raw1.b2    = keys_q[K_P1_B2]    | joystick_0[JOY_B2];
    raw1.b3    = keys_q[K_P1_B3]    | joystick_0[JOY_B3];
    raw1.start = keys_q[K_P1_START] | joystick_0[JOY_START];
    raw1.coin  = keys_q[K_P1_COIN]  | joystick_0[JOY_COIN];
    raw1.pause = keys_q[K_P1_PAUSE] | joystick_0[JOY_PAUSE];

    raw2.up    = keys_q[K_P2_UP]    | joystick_1[JOY_UP];
    raw2.down  = keys_q[K_P2_DOWN]  | joystick_1[JOY_DOWN];
    raw2.left  = keys_q[K_P2_LEFT]  | joystick_1[JOY_LEFT];
    raw2.right = keys_q[K_P2_RIGHT] | joystick_1[JOY_RIGHT];
    raw2.b1    = keys_q[K_P2_B1]    | joystick_1[JOY_B1];
    raw2.b2    = keys_q[K_P2_B2]    | joystick_1[JOY_B2];
    raw2.b3    = keys_q[K_P2_B3]    | joystick_1[JOY_B3];
    raw2.start = keys_q[K_P2_START] | joystick_1[JOY_START];
    raw2.coin  = keys_q[K_P2_COIN]  | joystick_1[JOY_COIN];
    raw2.pause = joystick_1[JOY_PAUSE];
  end

  assign b1_raw = {raw2.b1, raw1.b1};

`ifdef INPUT_AUTOFIRE_EN
  localparam logic [15:0] AF_PERIOD = 16'(AUTOFIRE_PERIOD);

  logic [1:0]  b1_prev_q;
  logic [1:0]  af_phase_q, af_phase_d;
  logic [15:0] af_cnt_q [2];
  logic [15:0] af_cnt_d [2];

  // af_cnt_q counts cycles already spent in the current phase; a fresh press restarts high
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      af_phase_d[p] = af_phase_q[p];
      af_cnt_d[p]   = af_cnt_q[p];
      if (b1_raw[p] && !b1_prev_q[p]) begin
        af_phase_d[p] = 1'b1;
        af_cnt_d[p]   = '0;
      end else if (af_cnt_q[p] == AF_PERIOD) begin
        af_phase_d[p] = ~af_phase_q[p];
        af_cnt_d[p]   = '0;
      end
      b1_out[p] = b1_raw[p] & (~autofire_en | af_phase_d[p]);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_sys_n) begin
    if (!reset_sys_n) begin
      b1_prev_q  <= '0;
      af_phase_q <= '0;
      for (int p = 0; p < 2; p++) begin
        af_cnt_q[p] <= '0;
      end
    end else begin
      b1_prev_q  <= b1_raw;
      af_phase_q <= af_phase_d;
      for (int p = 0; p < 2; p++) begin
        if (b1_raw[p]) begin
          af_cnt_q[p] <= af_cnt_d[p] + 16'd1;
        end
      end
    end
  end
`else
  logic [15:0] unused_af_period;
  assign unused_af_period = 16'(AUTOFIRE_PERIOD);
  assign b1_out = b1_raw;
`endif

  always_ff @(posedge clk_sys or negedge reset_sys_n) begin
    if (!reset_sys_n) begin
      p1_dir     <= '0;
      p1_buttons <= '0;
      p1_start   <= 1'b0;
      p1_pause   <= 1'b0;
      p2_dir     <= '0;
      p2_buttons <= '0;
      p2_start   <= 1'b0;
      p2_pause   <= 1'b0;
      service1   <= 1'b0;
      service2   <= 1'b0;
    end else begin
      p1_dir     <= {axis_resolve(raw1.up, raw1.down), axis_resolve(raw1.left, raw1.right)};
      p1_buttons <= {raw1.b3, raw1.b2, b1_out[0]};
      p1_start   <= raw1.start;
      p1_pause   <= raw1.pause;
      p2_dir     <= {axis_resolve(raw2.up, raw2.down), axis_resolve(raw2.left, raw2.right)};
      p2_buttons <= {raw2.b3, raw2.b2, b1_out[1]};
      p2_start   <= raw2.start;
      p2_pause   <= raw2.pause;
      service1   <= keys_q[K_SERVICE1];
      service2   <= keys_q[K_SERVICE2];
    end
  end

  coin_pulse #(
    .PULSE_CYCLES(COIN_PULSE_CYCLES)
  ) u_coin_p1 (
    .clk_sys    (clk_sys),
    .reset_sys_n(reset_sys_n),
    .coin_raw   (raw1.coin),
    .coin_out   (p1_coin)
  );

  coin_pulse #(
    .PULSE_CYCLES(COIN_PULSE_CYCLES)
  ) u_coin_p2 (
    .clk_sys    (clk_sys),
    .reset_sys_n(reset_sys_n),
    .coin_raw   (raw2.coin),
    .coin_out   (p2_coin)
  );

endmodule

// File: tb/tb_input_mapper.sv
// tb/tb_input_mapper.sv - directed and randomized bench for input_mapper (INPUT_AUTOFIRE_EN adds the autofire steps)
module tb_input_mapper;

  logic        clk_sys = 1'b0;
  logic        reset_sys_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [10:0] joystick_0 = '0;
  logic [10:0] joystick_1 = '0;
`ifdef INPUT_AUTOFIRE_EN
  logic        autofire_en = 1'b0;
`endif
  logic [3:0]  p1_dir, p2_dir;
  logic [2:0]  p1_buttons, p2_buttons;
  logic        p1_start, p1_coin, p1_pause, p2_start, p2_coin, p2_pause;
  logic        service1, service2;

  int checks = 0;
  int errors = 0;
  bit key_state [256];
  logic [7:0] codes [19] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h16, 8'h4D,
                             8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15, 8'h1E, 8'h46, 8'h45};

  input_mapper #(
    .COIN_PULSE_CYCLES(16),
    .AUTOFIRE_PERIOD  (8)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_sys_n(reset_sys_n),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
`ifdef INPUT_AUTOFIRE_EN
    .autofire_en(autofire_en),
`endif
    .p1_dir     (p1_dir),
    .p1_buttons (p1_buttons),
    .p1_start   (p1_start),
    .p1_coin    (p1_coin),
    .p1_pause   (p1_pause),
    .p2_dir     (p2_dir),
    .p2_buttons (p2_buttons),
    .p2_start   (p2_start),
    .p2_coin    (p2_coin),
    .p2_pause   (p2_pause),
    .service1   (service1),
    .service2   (service2)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [21:0] obs_vec();
    return {p1_dir, p1_buttons, p1_start, p1_coin, p1_pause,
            p2_dir, p2_buttons, p2_start, p2_coin, p2_pause, service1, service2};
  endfunction

  function automatic logic [1:0] axis(input logic a, input logic b);
    return (a && b) ? 2'b00 : {a, b};
  endfunction

  // Expected outputs from the current pressed-key set and joystick levels (coins held idle)
  function automatic logic [21:0] model_vec();
    logic u1, d1, l1, r1, u2, d2, l2, r2;
    logic [2:0] bt1, bt2;
    u1 = key_state[8'h75] | joystick_0[3];
    d1 = key_state[8'h72] | joystick_0[2];
    l1 = key_state[8'h6B] | joystick_0[1];
    r1 = key_state[8'h74] | joystick_0[0];
    u2 = key_state[8'h2D] | joystick_1[3];
    d2 = key_state[8'h2B] | joystick_1[2];
    l2 = key_state[8'h23] | joystick_1[1];
    r2 = key_state[8'h34] | joystick_1[0];
    bt1 = {key_state[8'h29] | joystick_0[6], key_state[8'h11] | joystick_0[5], key_state[8'h14] | joystick_0[4]};
    bt2 = {key_state[8'h15] | joystick_1[6], key_state[8'h1B] | joystick_1[5], key_state[8'h1C] | joystick_1[4]};
    return {axis(u1, d1), axis(l1, r1), bt1, key_state[8'h16] | joystick_0[7], 1'b0,
            key_state[8'h4D] | joystick_0[9],
            axis(u2, d2), axis(l2, r2), bt2, key_state[8'h1E] | joystick_1[7], 1'b0,
            joystick_1[9], key_state[8'h46], key_state[8'h45]};
  endfunction

  initial begin
    int highs, rises;
    logic last;
    logic [21:0] exp;
    logic [7:0] code;
    logic pressed;

    foreach (key_state[j]) key_state[j] = 1'b0;

    // Reset with a pressed-up event pending and coin held through release
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    joystick_0[8] = 1'b1;
    tick(); tick();
    check("reset_outputs", 32'(obs_vec()), 32'd0);
    reset_sys_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("no_event_after_release", 32'(obs_vec()), 32'd0);
    end
    joystick_0 = '0;
    tick();

    // Keyboard path: two cycles from event to output
    ps2_key = {1'b0, 1'b0, 1'b0, 8'h00};
    tick(); tick();
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    tick();
    check("kbd_press_lat1", 32'(p1_dir), 32'h0);
    tick();
    check("kbd_press_lat2", 32'(p1_dir), 32'h8);
    ps2_key = {1'b0, 1'b0, 1'b0, 8'h75};
    tick();
    check("kbd_release_lat1", 32'(p1_dir), 32'h8);
    tick();
    check("kbd_release_lat2", 32'(p1_dir), 32'h0);

    // Opposing directions
    joystick_0[3:2] = 2'b11;
    tick();
    check("dir_cancel", 32'(p1_dir[3:2]), 32'h0);
    joystick_0[3:2] = 2'b10;
    tick();
    check("dir_up_only", 32'(p1_dir[3:2]), 32'h2);
    joystick_0 = '0;
    tick();

    // P1 coin held 100 cycles, then released, then a second press
    for (int pass = 0; pass < 2; pass++) begin
      highs = 0; rises = 0; last = 1'b0;
      for (int i = 0; i < 120; i++) begin
        joystick_0[8] = (i < 100);
        tick();
        if (i == 0) check("p1_coin_first_cycle", 32'(p1_coin), 32'd1);
        if (p1_coin) highs++;
        if (p1_coin && !last) rises++;
        last = p1_coin;
      end
      check("p1_coin_width", highs, 16);
      check("p1_coin_pulses", rises, 1);
    end

    // P2 coin one-cycle press, re-press inside the pulse
    highs = 0; rises = 0; last = 1'b0;
    for (int i = 0; i < 40; i++) begin
      joystick_1[8] = (i == 0 || i == 5);
      tick();
      if (p2_coin) highs++;
      if (p2_coin && !last) rises++;
      last = p2_coin;
    end
    check("p2_coin_width", highs, 16);
    check("p2_coin_pulses", rises, 1);

    // Reset mid-pulse clears the coin output at once
    joystick_0[8] = 1'b1;
    tick();
    joystick_0[8] = 1'b0;
    tick(); tick(); tick(); tick();
    check("p1_coin_mid_pulse", 32'(p1_coin), 32'd1);
    reset_sys_n = 1'b0;
    #1;
    check("async_reset_coin", 32'(p1_coin), 32'd0);
    check("async_reset_all", 32'(obs_vec()), 32'd0);
    tick(); tick();
    reset_sys_n = 1'b1;
    tick();

    // Randomized keys and joysticks against the model
    for (int i = 0; i < 400; i++) begin
      joystick_0 = 11'($urandom) & ~11'h100;
      joystick_1 = 11'($urandom) & ~11'h100;
      if ($urandom_range(0, 2) == 0) begin
        int sel;
        sel = $urandom_range(0, 22);
        if (sel < 19) code = codes[sel];
        else begin
          code = 8'($urandom);
          if (code == 8'h2E || code == 8'h36) code = 8'h00;
        end
        pressed = 1'($urandom);
        ps2_key = {~ps2_key[10], pressed, 1'($urandom), code};
        exp = model_vec();
        key_state[code] = pressed;
      end else begin
        exp = model_vec();
      end
      tick();
      check("random_outputs", 32'(obs_vec()), 32'(exp));
    end

    joystick_0 = '0;
    joystick_1 = '0;
    reset_sys_n = 1'b0;
    #1;
    check("reset_after_random", 32'(obs_vec()), 32'd0);
    foreach (key_state[j]) key_state[j] = 1'b0;
    tick();
    reset_sys_n = 1'b1;
    tick();

`ifdef INPUT_AUTOFIRE_EN
    // Autofire: 8 high, 8 low while button 1 is held
    autofire_en = 1'b1;
    joystick_0[4] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("autofire_pattern", 32'(p1_buttons[0]), 32'(((i / 8) % 2) == 0));
    end
    reset_sys_n = 1'b0;
    #1;
    check("autofire_reset", 32'(obs_vec()), 32'd0);
    joystick_0 = '0;
    autofire_en = 1'b0;
    tick();
    reset_sys_n = 1'b1;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_mapper.md
INPUT_MAPPER -- requirements
Module: input_mapper

Interface
REQ-001 Parameter COIN_PULSE_CYCLES, default 16, is the width in clk_sys cycles of each shaped coin pulse; legal range 1..65535.
REQ-002 Parameter AUTOFIRE_PERIOD, default 8, is the half-period in clk_sys cycles of the autofire square wave; legal range 1..65535.
REQ-003 Port clk_sys, input, 1 bit: the one clock.
REQ-004 Port reset_sys_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port ps2_key, input, 11 bits: [10] event toggle, [9] pressed, [8] extended, [7:0] scan code.
REQ-006 Ports joystick_0 and joystick_1, input, 11 bits each: [0] right, [1] left, [2] down, [3] up, [6:4] buttons, [7] start, [8] coin, [9] pause.
REQ-007 Port autofire_en, input, 1 bit: autofire enable for button 1; present only with INPUT_AUTOFIRE_EN defined.
REQ-008 Ports p1_dir and p2_dir, output, 4 bits each: {up, down, left, right}.
REQ-009 Ports p1_buttons and p2_buttons, output, 3 bits each: {button3, button2, button1}.
REQ-010 Ports p1_start, p1_coin, p1_pause, p2_start, p2_coin, p2_pause, output, 1 bit each.
REQ-011 Ports service1 and service2, output, 1 bit each.

Function
REQ-012 A keyboard event SHALL be detected when ps2_key[10] differs from its registered previous value.
REQ-013 Detection SHALL be disarmed for the first cycle after reset release.
- During that cycle the previous-value register loads ps2_key[10] and no event is generated.
REQ-014 On an event, the key register selected by ps2_key[7:0] SHALL load ps2_key[9].
- ps2_key[8] is ignored.
- Unlisted codes change nothing.
REQ-015 The key map SHALL be:
- P1: 75 up, 72 down, 6B left, 74 right, 14 b1, 11 b2, 29 b3, 16 start, 2E coin, 4D pause.
- P2: 2D up, 2B down, 23 left, 34 right, 1C b1, 1B b2, 15 b3, 1E start, 36 coin.
- Service: 46 service1, 45 service2.
REQ-016 Each raw control SHALL be the OR of its key register and its joystick bit.
- p2 pause is joystick_1[9] only.
- service1 and service2 are keys only.
REQ-017 All outputs SHALL be registered.
- Latency from a joystick change to the output is 1 cycle.
- Latency from a keyboard event to the output is 2 cycles.
REQ-018 If raw up and raw down are both asserted, both SHALL be output 0; the same rule applies to left and right.
REQ-019 Each player's coin SHALL be shaped by an FSM with states IDLE, ACTIVE and HOLD.
- IDLE -> ACTIVE on a raw coin rising edge; the counter loads COIN_PULSE_CYCLES-1.
- ACTIVE: coin output is 1 and the counter decrements; at 0 go to HOLD.
- HOLD: coin output is 0; go to IDLE on the first cycle raw coin is 0.
REQ-020 Raw coin release during ACTIVE SHALL NOT shorten the pulse, and re-presses during ACTIVE or HOLD SHALL be ignored.
REQ-021 If raw coin is already 1 at reset release, it SHALL NOT count as a rising edge.
REQ-022 Counters SHALL be 16 bits with no wrap-around beyond the states defined above.

Reset
REQ-023 While reset_sys_n is 0, the block SHALL hold:
- all outputs, key registers and edge registers at 0;
- both coin FSMs in IDLE;
- all counters at 0;
- the autofire phase at 0.
REQ-024 Reset asserted mid-pulse SHALL abort the pulse immediately (asynchronous), and p*_coin SHALL be 0 in the same cycle.

Configuration
REQ-025 With INPUT_AUTOFIRE_EN defined, while autofire_en=1 and raw button 1 is held:
- button 1 output SHALL be raw button 1 AND a phase bit;
- the phase bit toggles every AUTOFIRE_PERIOD cycles and restarts at 1 on each raw press.
REQ-026 Without INPUT_AUTOFIRE_EN, port autofire_en and the autofire logic SHALL be absent, and button 1 SHALL pass through per REQ-016.

Structure
REQ-027 Package input_pkg SHALL hold:
- the scan-code constants;
- the joystick bit-index constants;
- the coin FSM state enum.
REQ-028 Sub-module coin_pulse SHALL implement REQ-019..REQ-022 and SHALL be instantiated once per player.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Toggle ps2_key to {1,1,0,0x75}: p1_dir=4'b1000 two cycles later. Toggle to {0,0,0,0x75}: p1_dir=0 two cycles later.
- Hold ps2_key[10]=1 through reset release: no event, all outputs stay 0.
- joystick_0[8] high for 100 cycles with COIN_PULSE_CYCLES=16: p1_coin high for exactly 16 cycles, once. Release then re-press: a second 16-cycle pulse.
- joystick_1[8] high for 1 cycle: p2_coin high for 16 cycles. Re-press at cycle 5: ignored.
- joystick_0[3:2]=2'b11: p1_dir[3:2]=00. joystick_0[3:2]=2'b10: p1_dir[3:2]=10.
- INPUT_AUTOFIRE_EN, AUTOFIRE_PERIOD=8, autofire_en=1, b1 held 40 cycles: p1_buttons[0] pattern is 8 cycles high, 8 low, repeating. Assert reset mid-run: all outputs 0 immediately.
